// File: rtl/hv_bundle_encoder_if.sv
// Connection bundle between the hypervector bundle encoder and its
// neighbours: control from the sequencer, the heads and pop requests of the
// two item-memory FIFOs, and the query hypervector handshake towards the
// associative-memory search stage.
interface hv_bundle_encoder_if #(
  parameter int HVDimension   = 512,
  parameter int NumItemsWidth = 16
);

  // Control
  logic                     clr_i;
  logic [1:0]               op_i;
  logic [NumItemsWidth-1:0] num_items_i;
  logic                     start_i;
  logic                     busy_o;

  // Item-memory FIFO side
  logic [HVDimension-1:0]   im_a_i;
  logic                     im_a_pop_o;
  logic [HVDimension-1:0]   im_b_i;
  logic                     im_b_pop_o;
  logic                     stall_i;

  // Query hypervector towards the search stage
  logic [HVDimension-1:0]   qhv_o;
  logic                     qhv_valid_o;
  logic                     qhv_ready_i;

  // The encoder itself
  modport slave (
    input  clr_i, op_i, num_items_i, start_i,
    input  im_a_i, im_b_i, stall_i,
    input  qhv_ready_i,
    output busy_o, im_a_pop_o, im_b_pop_o,
    output qhv_o, qhv_valid_o
  );

  // Whatever drives the encoder (sequencer, item memory, search stage)
  modport master (
    output clr_i, op_i, num_items_i, start_i,
    output im_a_i, im_b_i, stall_i,
    output qhv_ready_i,
    input  busy_o, im_a_pop_o, im_b_pop_o,
    input  qhv_o, qhv_valid_o
  );

endinterface

// File: rtl/hv_bundle_encoder.sv
// Hypervector bundle encoder.
// Pops pairs of hypervectors from the item-memory FIFOs, binds each pair
// (A, A^B or A^rotl1(B)), accumulates the bound bits into per-dimension
// saturating signed counters and finally binarizes the counters into one
// query hypervector offered on a valid/ready handshake.
module hv_bundle_encoder #(
  parameter int HVDimension   = 512,
  parameter int CounterWidth  = 8,
  parameter int NumItemsWidth = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  hv_bundle_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OpXor    = 2'd1;
  localparam logic [1:0] OpXorRot = 2'd2;

  // Saturation limits of a counter lane and the unit step.
  localparam logic signed [CounterWidth-1:0] CntMax = {1'b0, {(CounterWidth-1){1'b1}}};
  localparam logic signed [CounterWidth-1:0] CntMin = {1'b1, {(CounterWidth-1){1'b0}}};
  localparam logic signed [CounterWidth-1:0] CntOne = {{(CounterWidth-1){1'b0}}, 1'b1};

  state_t                   state_reg, state_next;
  logic [1:0]               op_reg, op_next;
  logic [NumItemsWidth-1:0] remaining_reg, remaining_next;
  logic [HVDimension-1:0]   qhv_reg;
  logic [HVDimension-1:0]   qhv_next;
  logic [HVDimension-1:0]   bound_vec;
  logic [HVDimension-1:0]   rot_b;
  logic                     cnt_clear;
  logic                     cnt_step;
  logic                     handshake;
  logic                     enter_done;
  logic                     soft_rst;

  // Reset and soft clear behave identically and beat every other input.
  assign soft_rst = rst_i | bus.clr_i;

  // Rotate-left by one: bit i of the result takes bit i-1 of B, bit 0 wraps
  // around from the top bit.
  assign rot_b = {bus.im_b_i[HVDimension-2:0], bus.im_b_i[HVDimension-1]};

  // Bind the current FIFO heads with the operation latched at start.
  always_comb begin
    bound_vec = bus.im_a_i;
    case (op_reg)
      OpXor:    bound_vec = bus.im_a_i ^ bus.im_b_i;
      OpXorRot: bound_vec = bus.im_a_i ^ rot_b;
      default:  bound_vec = bus.im_a_i;  // op 0 and the reserved op 3
    endcase
  end

  // Next-state logic and the per-cycle counter commands.
  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    remaining_next = remaining_reg;
    cnt_clear      = 1'b0;
    cnt_step       = 1'b0;
    handshake      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start_i) begin
          op_next        = bus.op_i;
          remaining_next = bus.num_items_i;
          cnt_clear      = 1'b1;
          state_next     = (bus.num_items_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // A stalled cycle means the pop found an empty FIFO: the heads are
        // not real data, so nothing is accumulated and the pops stay up.
        if (!bus.stall_i) begin
          cnt_step       = 1'b1;
          remaining_next = remaining_reg - NumItemsWidth'(1);
          if (remaining_reg == NumItemsWidth'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (bus.qhv_ready_i) begin
          handshake  = 1'b1;
          cnt_clear  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The query vector is captured exactly once, on the edge that enters DONE.
  assign enter_done = (state_reg != DONE) && (state_next == DONE);

  // Control state registers.
  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state_reg     <= IDLE;
      op_reg        <= 2'd0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      remaining_reg <= remaining_next;
    end
  end

  // Query hypervector register: loaded on entry to DONE, held while the
  // consumer back-pressures, cleared once it has been taken.
  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      qhv_reg <= '0;
    end else if (enter_done) begin
      qhv_reg <= qhv_next;
    end else if (handshake) begin
      qhv_reg <= '0;
    end
  end

  // One saturating signed counter per dimension.
  generate
    for (genvar gi = 0; gi < HVDimension; gi++) begin : g_lane
      logic signed [CounterWidth-1:0] cnt_reg;
      logic signed [CounterWidth-1:0] cnt_next;

      // Counter update: +1 for a set bound bit, -1 otherwise, holding at
      // the limits instead of wrapping.
      always_comb begin
        cnt_next = cnt_reg;
        if (cnt_clear) begin
          cnt_next = '0;
        end else if (cnt_step) begin
          if (bound_vec[gi]) begin
            if (cnt_reg != CntMax) begin
              cnt_next = cnt_reg + CntOne;
            end
          end else begin
            if (cnt_reg != CntMin) begin
              cnt_next = cnt_reg - CntOne;
            end
          end
        end
      end

      // Counter register.
      always_ff @(posedge clk_i) begin
        if (soft_rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      // Binarize: non-negative (ties included) maps to 1.
      assign qhv_next[gi] = ~cnt_next[CounterWidth-1];
    end
  endgenerate

  // Outputs decode the registered state only, so pops drop on the very
  // first cycle after leaving RUN, whatever the reason for leaving.
  assign bus.busy_o      = (state_reg != IDLE);
  assign bus.im_a_pop_o  = (state_reg == RUN);
  assign bus.im_b_pop_o  = (state_reg == RUN) && ((op_reg == OpXor) || (op_reg == OpXorRot));
  assign bus.qhv_valid_o = (state_reg == DONE);
  assign bus.qhv_o       = qhv_reg;

endmodule

// File: tb/tb_hv_bundle_encoder.sv
// Self-checking bench for hv_bundle_encoder: directed scenarios followed by
// randomized jobs, each result compared with a behavioural bundling model.
module tb_hv_bundle_encoder;

  localparam int D  = 8;
  localparam int CW = 4;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  hv_bundle_encoder_if #(.HVDimension(D), .NumItemsWidth(NW)) bus ();

  hv_bundle_encoder #(
    .HVDimension  (D),
    .CounterWidth (CW),
    .NumItemsWidth(NW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [D-1:0] qa[$];
  logic [D-1:0] qb[$];
  int           stall_at[$];
  bit           rand_stall = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit stall_listed(input int c);
    for (int i = 0; i < stall_at.size(); i++) begin
      if (stall_at[i] == c) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Behavioural model: integer tallies per dimension, clamped to the
  // counter range after every item, then thresholded at zero.
  function automatic logic [D-1:0] model(input logic [1:0] op, input int n);
    int           cnt[D];
    int           lo;
    int           hi;
    logic [D-1:0] a;
    logic [D-1:0] b;
    logic [D-1:0] res;
    logic         bit_v;
    lo = -(1 << (CW - 1));
    hi = (1 << (CW - 1)) - 1;
    for (int d = 0; d < D; d++) cnt[d] = 0;
    for (int k = 0; k < n; k++) begin
      a = qa[k];
      b = qb[k];
      for (int d = 0; d < D; d++) begin
        if (op == 2'd1)      bit_v = a[d] ^ b[d];
        else if (op == 2'd2) bit_v = a[d] ^ b[(d + D - 1) % D];
        else                 bit_v = a[d];
        cnt[d] = cnt[d] + (bit_v ? 1 : -1);
        if (cnt[d] > hi) cnt[d] = hi;
        if (cnt[d] < lo) cnt[d] = lo;
      end
    end
    for (int d = 0; d < D; d++) res[d] = (cnt[d] >= 0);
    return res;
  endfunction

  // Runs one job from start to handshake, acting as the item-memory FIFOs.
  task automatic run_job(input string tag, input logic [1:0] op, input int n,
                         input int ready_delay, input bit has_exp, input logic [D-1:0] exp_qhv);
    int           idx;
    int           stalls;
    int           c;
    bit           got;
    bit           b_exp;
    logic [D-1:0] ref_qhv;
    logic [D-1:0] held;
    idx     = 0;
    stalls  = 0;
    c       = 1;
    got     = 1'b0;
    b_exp   = (op == 2'd1) || (op == 2'd2);
    ref_qhv = model(op, n);
    @(negedge clk);
    bus.op_i        = op;
    bus.num_items_i = NW'(n);
    bus.start_i     = 1'b1;
    bus.qhv_ready_i = (ready_delay == 0);
    @(negedge clk);
    bus.start_i = 1'b0;
    while (!got && c <= 200) begin
      bus.stall_i = stall_listed(c) || (rand_stall && ($urandom_range(0, 3) == 0));
      bus.im_a_i  = (idx < qa.size()) ? qa[idx] : '0;
      bus.im_b_i  = (idx < qb.size()) ? qb[idx] : '0;
      #1;
      if (bus.qhv_valid_o) begin
        got = 1'b1;
        bus.stall_i = 1'b0;
        check({tag, "/latency"}, c, n + stalls + 1);
        check({tag, "/qhv_model"}, bus.qhv_o, ref_qhv);
        if (has_exp) check({tag, "/qhv_exp"}, bus.qhv_o, exp_qhv);
        check({tag, "/done_busy_pops"}, {bus.busy_o, bus.im_a_pop_o, bus.im_b_pop_o}, 3'b100);
        held = bus.qhv_o;
        for (int k = 0; k < ready_delay; k++) begin
          bus.start_i     = 1'b1;
          bus.op_i        = 2'($urandom_range(0, 3));
          bus.num_items_i = NW'($urandom_range(1, 9));
          @(negedge clk);
          #1;
          check({tag, "/bp_valid"}, bus.qhv_valid_o, 1'b1);
          check({tag, "/bp_qhv"}, bus.qhv_o, held);
        end
        bus.start_i     = 1'b0;
        bus.qhv_ready_i = 1'b1;
        @(negedge clk);
        #1;
        check({tag, "/after_hs"}, {bus.qhv_valid_o, bus.busy_o, bus.im_a_pop_o, bus.im_b_pop_o}, 4'b0000);
      end else begin
        check({tag, "/run_busy_pops"}, {bus.busy_o, bus.im_a_pop_o, bus.im_b_pop_o}, {2'b11, b_exp});
        if (bus.stall_i) stalls++;
        else idx++;
        @(negedge clk);
      end
      c++;
    end
    bus.stall_i = 1'b0;
    if (!got) check({tag, "/timeout_valid"}, bus.qhv_valid_o, 1'b1);
    $display("job %s op=%0d n=%0d stalls=%0d qhv=0x%0h model=0x%0h", tag, op, n, stalls, bus.qhv_o, ref_qhv);
  endtask

  // Starts a 5-item job, lets two items through, then kills it.
  task automatic abort_job(input string tag, input bit use_clr);
    qa = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    qb = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    @(negedge clk);
    bus.op_i        = 2'd0;
    bus.num_items_i = NW'(5);
    bus.start_i     = 1'b1;
    bus.qhv_ready_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.stall_i = 1'b0;
    bus.im_a_i  = qa[0];
    @(negedge clk);
    bus.im_a_i = qa[1];
    @(negedge clk);
    #1;
    check({tag, "/pre_abort"}, {bus.busy_o, bus.im_a_pop_o}, 2'b11);
    if (use_clr) bus.clr_i = 1'b1;
    else         rst = 1'b1;
    @(negedge clk);
    #1;
    check({tag, "/abort_outs"}, {bus.busy_o, bus.im_a_pop_o, bus.im_b_pop_o, bus.qhv_valid_o}, 4'b0000);
    bus.clr_i = 1'b0;
    rst       = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check({tag, "/idle_quiet"}, {bus.busy_o, bus.qhv_valid_o}, 2'b00);
    end
    $display("abort %s done", tag);
    qa = '{8'h00};
    qb = '{8'h00};
    run_job({tag, "_restart"}, 2'd0, 1, 0, 1'b1, 8'h00);
  endtask

  initial begin
    int n;
    int rd;
    logic [1:0] op;
    bus.clr_i       = 1'b0;
    bus.op_i        = 2'd0;
    bus.num_items_i = '0;
    bus.start_i     = 1'b0;
    bus.im_a_i      = '0;
    bus.im_b_i      = '0;
    bus.stall_i     = 1'b0;
    bus.qhv_ready_i = 1'b1;
    rst             = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outs", {bus.busy_o, bus.im_a_pop_o, bus.im_b_pop_o, bus.qhv_valid_o}, 4'b0000);
    check("reset_qhv", bus.qhv_o, 8'h00);
    rst = 1'b0;
    $display("reset checked");

    qa = '{8'hFF, 8'h0F, 8'h00};
    qb = '{8'h00, 8'h00, 8'h00};
    run_job("op0_n3", 2'd0, 3, 0, 1'b1, 8'h0F);

    qa = '{8'hAA};
    qb = '{8'hFF};
    run_job("op1_xor", 2'd1, 1, 0, 1'b1, 8'h55);

    qa = '{8'h00};
    qb = '{8'h81};
    run_job("op2_rot", 2'd2, 1, 0, 1'b1, 8'h03);

    qa = '{8'hFF, 8'h0F, 8'h00};
    qb = '{8'h00, 8'h00, 8'h00};
    stall_at = '{2, 3};
    run_job("stall", 2'd0, 3, 0, 1'b1, 8'h0F);
    stall_at.delete();

    qa.delete();
    qb.delete();
    for (int k = 0; k < 12; k++) begin qa.push_back(8'hFF); qb.push_back(8'h00); end
    for (int k = 0; k < 8; k++)  begin qa.push_back(8'h00); qb.push_back(8'h00); end
    run_job("saturate", 2'd0, 20, 0, 1'b1, 8'h00);

    qa = '{8'h3C, 8'hC3};
    qb = '{8'h00, 8'h00};
    run_job("backpressure", 2'd0, 2, 5, 1'b0, 8'h00);

    qa.delete();
    qb.delete();
    run_job("n_zero", 2'd0, 0, 0, 1'b1, 8'hFF);

    abort_job("clr_mid_run", 1'b1);
    abort_job("rst_mid_run", 1'b0);

    rand_stall = 1'b1;
    for (int j = 0; j < 8; j++) begin
      op = 2'($urandom_range(0, 3));
      n  = $urandom_range(0, 14);
      rd = $urandom_range(0, 3);
      qa.delete();
      qb.delete();
      for (int k = 0; k < n; k++) begin
        qa.push_back(D'($urandom));
        qb.push_back(D'($urandom));
      end
      run_job($sformatf("rand%0d", j), op, n, rd, 1'b0, 8'h00);
    end
    rand_stall = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
